digital_tube_scan: RTL and testbench
====================================

DIGITAL_TUBE_SCAN -- requirements
Module: digital_tube_scan

Interface
REQ-001 Parameter SCAN_DIV, default 100000: clk cycles each digit slot is held; legal range >= 2.
REQ-002 clk  input  1  single system clock (cpu_clk domain); all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 wen  input  1  write strobe for the display value (DigitalCtrl & IOWrite from the CPU I/O path).
REQ-005 wdata  input  32  value to display, 8 hex nibbles.
REQ-006 blank_lz  input  1  1 = leading-zero blanking enabled; sampled every cycle.
REQ-007 seg  output  8  segment drive, active-low; seg[0]=a ... seg[6]=g, seg[7]=dp.
REQ-008 an  output  8  digit enables, active-low; an[i] selects digit i, digit 0 rightmost.

Function
REQ-009 Internal 32-bit value register: loads wdata on any clk edge where wen=1 and rst=0; otherwise holds.
REQ-010 Prescaler counts 0..SCAN_DIV-1 and wraps to 0; terminal count (SCAN_DIV-1) produces a one-cycle tick.
REQ-011 3-bit digit index advances by 1 on each tick; 7 wraps to 0; unchanged when no tick.
REQ-012 seg and an are registered: at each edge they load the decode of the current index and value register (one-cycle output latency).
REQ-013 an = all ones except bit [index] = 0; exactly one bit low whenever not in reset state.
REQ-014 Digit i shows nibble value[4i+3:4i].
REQ-015 Hex decode (seg hex, dp off): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
REQ-016 Leading-zero blanking: when blank_lz=1, digit i (i>=1) drives seg=FF if value[31:4i] == 0; digit 0 is never blanked; an unaffected by blanking.
REQ-017 blank_lz=0: every digit decoded per REQ-015, including zeros.
REQ-018 Write latency: wdata with wen at edge N enters value at N; seg reflects it at edge N+1 for the digit then selected.
REQ-019 Write coincident with tick: both take effect at the same edge; no slot is skipped or repeated.
REQ-020 Back-to-back writes: last write wins; no buffering of intermediate values.
REQ-021 dp (seg[7]) always 1.

Reset
REQ-022 rst=1 at an edge: value=0, prescaler=0, index=0, seg=FF, an=FF; wen ignored in that cycle.
REQ-023 First cycle after rst deasserts: outputs show digit 0 (an=FE, seg=C0 for value 0); the digit 0 slot lasts SCAN_DIV cycles from that point.
REQ-024 Reset asserted mid-slot or mid-write: aborts immediately at next edge to REQ-022 state; no partial value retained.

Verification
REQ-025 SCAN_DIV=4, reset, no writes -> an cycles FE,FD,FB,F7,EF,DF,BF,7F every 4 cycles, then FE again; seg=C0 every slot.
REQ-026 wen with wdata=0x0123ABCD, blank_lz=0 -> slots 0..7 show seg A1,C6,83,88,B0,A4,F9,C0.
REQ-027 wdata=0x000000A5, blank_lz=1 -> digit0 seg=92, digit1 seg=88, digits 2..7 seg=FF with an still scanning.
REQ-028 wdata=0x00000000, blank_lz=1 -> digit 0 seg=C0, digits 1..7 seg=FF.
REQ-029 Write 0x11111111 then 0x22222222 on consecutive cycles during digit 3 slot -> seg goes F9 then A4 one cycle after each write, final A4; slot timing unchanged.
REQ-030 rst pulsed mid digit-5 slot after write of 0xFFFFFFFF -> next edge an=FF, seg=FF; after release an=FE, seg=C0.

Source files
------------

// File: rtl/digital_tube_scan.sv
// Eight-digit multiplexed hex display driver with optional leading-zero blanking.
// One-cycle registered outputs; no backpressure, writes are accepted every cycle.
// Each digit slot is held for SCAN_DIV clock cycles.
module digital_tube_scan #(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wen,
    input  logic [31:0] wdata,
    input  logic        blank_lz,
    output logic [7:0]  seg,
    output logic [7:0]  an
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] presc;
    logic          tick;
    logic [2:0]    idx;
    logic [31:0]   value;
    logic [3:0]    nib;
    logic [31:0]   upper;
    logic          blank;
    logic [7:0]    seg_nxt;
    logic [7:0]    an_nxt;

    function automatic logic [7:0] hex_seg(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    assign tick = (presc == CW'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
            value <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                idx <= idx + 3'd1;
            end
            if (wen) begin
                value <= wdata;
            end
        end
    end

    // A digit is blanked only when it and every more significant nibble are zero.
    always_comb begin
        nib     = value[{idx, 2'b00} +: 4];
        upper   = value >> {idx, 2'b00};
        blank   = blank_lz && (idx != 3'd0) && (upper == 32'd0);
        seg_nxt = blank ? 8'hFF : hex_seg(nib);
        an_nxt  = ~(8'b1 << idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= 8'hFF;
            an  <= 8'hFF;
        end else begin
            seg <= seg_nxt;
            an  <= an_nxt;
        end
    end

endmodule

// File: tb/tb_digital_tube_scan.sv
// Bench for digital_tube_scan: cycle-count based display model checked every cycle,
// plus directed slot-by-slot literal checks.
module tb_digital_tube_scan;

    localparam int SD = 4;

    logic        clk;
    logic        rst;
    logic        wen;
    logic [31:0] wdata;
    logic        blank_lz;
    logic [7:0]  seg;
    logic [7:0]  an;

    int n_cmp  = 0;
    int n_fail = 0;
    int tcyc   = 0;

    digital_tube_scan #(.SCAN_DIV(SD)) dut (
        .clk      (clk),
        .rst      (rst),
        .wen      (wen),
        .wdata    (wdata),
        .blank_lz (blank_lz),
        .seg      (seg),
        .an       (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: displayed digit follows from the number of cycles since reset release.
    logic [7:0]  hex_tab [16];
    logic [31:0] mv;
    int          mcyc;
    logic        mvalid;
    logic [7:0]  exp_seg;
    logic [7:0]  exp_an;

    initial begin
        hex_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        mvalid = 1'b0;
        mv     = '0;
        mcyc   = 0;
    end

    always @(posedge clk) begin
        int d;
        if (rst) begin
            exp_seg <= 8'hFF;
            exp_an  <= 8'hFF;
            mv      <= '0;
            mcyc    <= 0;
        end else begin
            d = (mcyc / SD) % 8;
            exp_an <= 8'hFF ^ (8'h01 << d);
            if (blank_lz && d != 0 && (mv >> (4 * d)) == 0)
                exp_seg <= 8'hFF;
            else
                exp_seg <= hex_tab[(mv >> (4 * d)) & 32'hF];
            mcyc <= mcyc + 1;
            if (wen) mv <= wdata;
        end
        mvalid <= 1'b1;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mvalid) begin
            check("model_seg", seg, exp_seg);
            check("model_an", an, exp_an);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            tcyc++;
        end
    endtask

    function automatic bit at_slot(input int j, input int ph);
        return tcyc >= 1 && ((tcyc - 1) / SD) % 8 == j && (tcyc - 1) % SD == ph;
    endfunction

    task automatic wait_slot(input int j, input int ph);
        int n;
        n = 0;
        do begin
            step(1);
            n++;
        end while (!at_slot(j, ph) && n < 80);
        if (!at_slot(j, ph)) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_slot: digit %0d phase %0d not reached", j, ph);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        check("reset_an", an, 8'hFF);
        check("reset_seg", seg, 8'hFF);
        rst  = 1'b0;
        tcyc = 0;
    endtask

    task automatic write(input logic [31:0] v);
        wen   = 1'b1;
        wdata = v;
        step(1);
        wen   = 1'b0;
    endtask

    logic [7:0] an_lit [8];
    logic [7:0] s26 [8];
    logic [7:0] s27 [8];

    initial begin
        an_lit = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        s26    = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
        s27    = '{8'h92, 8'h88, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        rst = 1'b1; wen = 1'b0; wdata = '0; blank_lz = 1'b0;

        // Reset scan with no writes.
        do_reset();
        step(1);
        check("first_an", an, 8'hFE);
        check("first_seg", seg, 8'hC0);
        for (int j = 0; j < 9; j++) begin
            wait_slot(j % 8, 1);
            check("scan_an", an, an_lit[j % 8]);
            check("scan_seg", seg, 8'hC0);
        end

        // Full hex decode, no blanking.
        write(32'h0123ABCD);
        for (int j = 0; j < 8; j++) begin
            wait_slot(j, 1);
            check("hex_seg", seg, s26[j]);
            check("hex_an", an, an_lit[j]);
        end

        // Leading-zero blanking.
        blank_lz = 1'b1;
        write(32'h000000A5);
        for (int j = 0; j < 8; j++) begin
            wait_slot(j, 2);
            check("blank_seg", seg, s27[j]);
            check("blank_an", an, an_lit[j]);
        end
        write(32'h00000000);
        for (int j = 0; j < 8; j++) begin
            wait_slot(j, 2);
            check("zero_seg", seg, (j == 0) ? 8'hC0 : 8'hFF);
        end

        // Back-to-back writes at the start of digit 3.
        blank_lz = 1'b0;
        wait_slot(3, 0);
        wen = 1'b1; wdata = 32'h11111111;
        step(1);
        check("b2b_old", seg, 8'hC0);
        wdata = 32'h22222222;
        step(1);
        check("b2b_first", seg, 8'hF9);
        wen = 1'b0;
        step(1);
        check("b2b_last", seg, 8'hA4);
        check("b2b_an", an, 8'hF7);
        step(1);
        check("b2b_slot_end", an, 8'hEF);
        check("b2b_slot_seg", seg, 8'hA4);

        // Reset mid digit-5 slot, with a write presented during reset.
        write(32'hFFFFFFFF);
        wait_slot(5, 1);
        check("pre_rst_seg", seg, 8'h8E);
        rst = 1'b1; wen = 1'b1; wdata = 32'h55555555;
        step(1);
        check("midrst_an", an, 8'hFF);
        check("midrst_seg", seg, 8'hFF);
        rst = 1'b0; wen = 1'b0; tcyc = 0;
        step(1);
        check("rel_an", an, 8'hFE);
        check("rel_seg", seg, 8'hC0);
        wait_slot(1, 1);
        check("rel_d1_seg", seg, 8'hC0);

        // Mixed writes and blanking toggles, checked by the model only.
        for (int k = 0; k < 30; k++) begin
            blank_lz = 1'($urandom_range(0, 1));
            write($urandom >> $urandom_range(0, 31));
            step($urandom_range(0, 9));
        end
        step(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
